// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared state encoding and default parameters for the pipeline stall controller
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_HALT     = 3'd3
    } ctrl_state_t;

    localparam int DEFAULT_FLUSH_CYCLES = 1;
    localparam int DEFAULT_MAX_WAIT     = 15;

endpackage

// File: rtl/stall_wait_timer.sv
// rtl/stall_wait_timer.sv - saturating memory-wait counter with timeout compare
module stall_wait_timer
    import pipeline_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int W = $clog2(MAX_WAIT + 2);
    localparam logic [W-1:0] SAT   = W'(MAX_WAIT + 1);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] cnt_q, cnt_d;

    // Wait count register; clears whenever the controller is neither starting nor counting
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // Load 1 on the first busy cycle, then count up and stick at MAX_WAIT+1
    always_comb begin
        cnt_d = '0;
        if (start_i)
            cnt_d = W'(1);
        else if (count_i)
            cnt_d = (cnt_q == SAT) ? SAT : cnt_q + W'(1);
    end

    // Another busy cycle while already at MAX_WAIT makes the run longer than allowed
    assign expired_o = count_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - pipeline stall/flush/bubble sequencer; STALL_PERF_COUNTERS_EN adds stall/flush cycle counters
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter int MAX_WAIT     = DEFAULT_MAX_WAIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       loadUseHazard,
    input  logic       branchTaken,
    input  logic       memBusy,
    input  logic       haltReq,
    input  logic       resumeReq,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       ifIdFlush,
    output logic       idExBubble,
    output logic       exMemWrite,
    output logic       memWbBubble,
    output logic [2:0] ctrlState,
    output logic       timeout
`ifdef STALL_PERF_COUNTERS_EN
    ,
    output logic [31:0] stallCycles,
    output logic [31:0] flushCycles
`endif
);

    localparam logic [2:0] FLUSH_LOAD   = 3'(FLUSH_CYCLES);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    ctrl_state_t state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        pending_branch_q, pending_branch_d;
    logic        timeout_q, timeout_d;
    logic        tmr_start, tmr_count, tmr_expired;

    stall_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .start_i   (tmr_start),
        .count_i   (tmr_count),
        .expired_o (tmr_expired)
    );

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_RUN;
            flush_cnt_q      <= '0;
            pending_branch_q <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            pending_branch_q <= pending_branch_d;
            timeout_q        <= timeout_d;
        end
    end

    // Next-state and Mealy outputs; reset holds the RUN defaults
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        pending_branch_d = pending_branch_q;
        timeout_d        = timeout_q;
        tmr_start        = 1'b0;
        tmr_count        = 1'b0;
        pcWrite          = 1'b1;
        ifIdWrite        = 1'b1;
        ifIdFlush        = 1'b0;
        idExBubble       = 1'b0;
        exMemWrite       = 1'b1;
        memWbBubble      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (memBusy) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        exMemWrite  = 1'b0;
                        memWbBubble = 1'b1;
                        tmr_start   = 1'b1;
                        state_d     = ST_MEM_WAIT;
                        if (branchTaken) pending_branch_d = 1'b1;
                    end else if (branchTaken) begin
                        ifIdFlush  = 1'b1;
                        idExBubble = 1'b1;
                        if (FLUSH_RELOAD != 3'd0) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FLUSH_RELOAD;
                        end
                    end else if (loadUseHazard) begin
                        pcWrite    = 1'b0;
                        ifIdWrite  = 1'b0;
                        idExBubble = 1'b1;
                    end else if (haltReq) begin
                        state_d = ST_HALT;
                    end
                end
                ST_FLUSH: begin
                    if (memBusy) begin
                        // Freeze takes over; flush_cnt_q is kept as the remaining count
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        exMemWrite  = 1'b0;
                        memWbBubble = 1'b1;
                        tmr_start   = 1'b1;
                        state_d     = ST_MEM_WAIT;
                        if (branchTaken) pending_branch_d = 1'b1;
                    end else begin
                        ifIdFlush = 1'b1;
                        if (branchTaken) begin
                            idExBubble  = 1'b1;
                            flush_cnt_d = FLUSH_RELOAD;
                            if (FLUSH_RELOAD == 3'd0) state_d = ST_RUN;
                        end else if (flush_cnt_q <= 3'd1) begin
                            flush_cnt_d = '0;
                            state_d     = ST_RUN;
                        end else begin
                            flush_cnt_d = flush_cnt_q - 3'd1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (memBusy) begin
                        pcWrite     = 1'b0;
                        ifIdWrite   = 1'b0;
                        exMemWrite  = 1'b0;
                        memWbBubble = 1'b1;
                        tmr_count   = 1'b1;
                        if (branchTaken) pending_branch_d = 1'b1;
                        if (tmr_expired) begin
                            timeout_d        = 1'b1;
                            pending_branch_d = 1'b0;
                            state_d          = ST_HALT;
                        end
                    end else if (pending_branch_q || branchTaken) begin
                        // A branch seen during the freeze gets its full flush afterwards
                        pending_branch_d = 1'b0;
                        flush_cnt_d      = FLUSH_LOAD;
                        state_d          = ST_FLUSH;
                    end else if (flush_cnt_q != 3'd0) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    pcWrite     = 1'b0;
                    ifIdWrite   = 1'b0;
                    exMemWrite  = 1'b0;
                    idExBubble  = 1'b1;
                    memWbBubble = 1'b1;
                    if (resumeReq && !timeout_q) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign ctrlState = state_q;
    assign timeout   = timeout_q;

`ifdef STALL_PERF_COUNTERS_EN
    logic [31:0] stall_cycles_q, flush_cycles_q;

    // Free-running wrap-around counts of stalled-PC and flushing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_cycles_q <= '0;
        end else begin
            if (!pcWrite)  stall_cycles_q <= stall_cycles_q + 32'd1;
            if (ifIdFlush) flush_cycles_q <= flush_cycles_q + 32'd1;
        end
    end

    assign stallCycles = stall_cycles_q;
    assign flushCycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    // {pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble}
    localparam logic [5:0] C_RUN    = 6'b110010;
    localparam logic [5:0] C_LU     = 6'b000110;
    localparam logic [5:0] C_BRANCH = 6'b111110;
    localparam logic [5:0] C_FLUSH  = 6'b111010;
    localparam logic [5:0] C_FREEZE = 6'b000001;
    localparam logic [5:0] C_HALT   = 6'b000101;

    logic       clk = 1'b0;
    logic       rst;
    logic       loadUseHazard, branchTaken, memBusy, haltReq, resumeReq;
    logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble;
    logic [2:0] ctrlState;
    logic       timeout;
`ifdef STALL_PERF_COUNTERS_EN
    logic [31:0] stallCycles, flushCycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.FLUSH_CYCLES(3), .MAX_WAIT(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .loadUseHazard (loadUseHazard),
        .branchTaken   (branchTaken),
        .memBusy       (memBusy),
        .haltReq       (haltReq),
        .resumeReq     (resumeReq),
        .pcWrite       (pcWrite),
        .ifIdWrite     (ifIdWrite),
        .ifIdFlush     (ifIdFlush),
        .idExBubble    (idExBubble),
        .exMemWrite    (exMemWrite),
        .memWbBubble   (memWbBubble),
        .ctrlState     (ctrlState),
        .timeout       (timeout)
`ifdef STALL_PERF_COUNTERS_EN
        ,
        .stallCycles   (stallCycles),
        .flushCycles   (flushCycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive this cycle's inputs just after the edge, then let combinational outputs settle
    task automatic drive(input logic lu, input logic br, input logic mb, input logic hr, input logic rr);
        loadUseHazard = lu;
        branchTaken   = br;
        memBusy       = mb;
        haltReq       = hr;
        resumeReq     = rr;
        #2;
    endtask

    task automatic expect_cycle(input string tag, input logic [5:0] ctl, input logic [2:0] st, input logic to);
        check({tag, ".ctl"}, 32'({pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble}), 32'(ctl));
        check({tag, ".state"}, 32'(ctrlState), 32'(st));
        check({tag, ".timeout"}, 32'(timeout), 32'(to));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("reset", C_RUN, 3'd0, 1'b0);
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        expect_cycle("idle", C_RUN, 3'd0, 1'b0);

        next_cycle();
        drive(1, 0, 0, 0, 0);
        expect_cycle("lu_stall", C_LU, 3'd0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("lu_after", C_RUN, 3'd0, 1'b0);

        next_cycle();
        drive(0, 1, 0, 0, 0);
        expect_cycle("br0", C_BRANCH, 3'd0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("br1", C_FLUSH, 3'd1, 1'b0);
        next_cycle();
        expect_cycle("br2", C_FLUSH, 3'd1, 1'b0);
        next_cycle();
        expect_cycle("br3", C_RUN, 3'd0, 1'b0);

        next_cycle();
        drive(1, 1, 0, 0, 0);
        expect_cycle("br_lu", C_BRANCH, 3'd0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("br_lu1", C_FLUSH, 3'd1, 1'b0);
        next_cycle();
        expect_cycle("br_lu2", C_FLUSH, 3'd1, 1'b0);
        next_cycle();
        expect_cycle("br_lu3", C_RUN, 3'd0, 1'b0);

        // Four busy cycles with a branch in the second, then deferred flush
        next_cycle();
        drive(0, 0, 1, 0, 0);
        expect_cycle("mb1", C_FREEZE, 3'd0, 1'b0);
        next_cycle();
        drive(0, 1, 1, 0, 0);
        expect_cycle("mb2", C_FREEZE, 3'd2, 1'b0);
        for (int i = 3; i <= 4; i++) begin
            next_cycle();
            drive(0, 0, 1, 0, 0);
            expect_cycle($sformatf("mb%0d", i), C_FREEZE, 3'd2, 1'b0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("mb_exit", C_RUN, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            expect_cycle($sformatf("mb_fl%0d", i), C_FLUSH, 3'd1, 1'b0);
        end
        next_cycle();
        expect_cycle("mb_done", C_RUN, 3'd0, 1'b0);

        // Longest legal busy run: 15 cycles, no timeout
        for (int i = 1; i <= 15; i++) begin
            next_cycle();
            drive(0, 0, 1, 0, 0);
            expect_cycle($sformatf("legal%0d", i), C_FREEZE, (i == 1) ? 3'd0 : 3'd2, 1'b0);
        end
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("legal_exit", C_RUN, 3'd2, 1'b0);
        next_cycle();
        expect_cycle("legal_done", C_RUN, 3'd0, 1'b0);

        // Busy for 20 cycles: the 16th busy cycle trips timeout
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            drive(0, 0, 1, 0, 0);
            if (i <= 16)
                expect_cycle($sformatf("to%0d", i), C_FREEZE, (i == 1) ? 3'd0 : 3'd2, 1'b0);
            else
                expect_cycle($sformatf("to%0d", i), C_HALT, 3'd3, 1'b1);
        end
        next_cycle();
        drive(0, 0, 0, 0, 1);
        expect_cycle("to_resume", C_HALT, 3'd3, 1'b1);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("to_stuck", C_HALT, 3'd3, 1'b1);
        rst = 1'b1;
        #1;
        check("to_rst_ctl", 32'({pcWrite, ifIdWrite, ifIdFlush, idExBubble, exMemWrite, memWbBubble}), 32'(C_RUN));
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        expect_cycle("to_cleared", C_RUN, 3'd0, 1'b0);

        next_cycle();
        drive(0, 0, 0, 1, 0);
        expect_cycle("halt_req", C_RUN, 3'd0, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("halted", C_HALT, 3'd3, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 1);
        expect_cycle("resume", C_HALT, 3'd3, 1'b0);
        next_cycle();
        drive(0, 0, 0, 0, 0);
        expect_cycle("resumed", C_RUN, 3'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
